probe_scan_display: RTL and testbench

//  Parametrised debug-probe viewer for the board top: selects one of NUM_CH observation words (pc, ir, mdr, F, ...),

---
 rtl/probe_scan_display_pkg.sv | 14 +
 rtl/probe_scan_display_seg7_hex_decode.sv | 9 +
 rtl/probe_scan_display.sv | 75 +++++++
 tb/tb_probe_scan_display.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/probe_scan_display_pkg.sv
// probe_scan_display_pkg: mode encodings and active-low 7-segment hex patterns
package probe_scan_display_pkg;
    typedef enum logic [1:0] {
        MODE_LIVE   = 2'd0,
        MODE_HOLD   = 2'd1,
        MODE_STROBE = 2'd2,
        MODE_LIVE3  = 2'd3
    } mode_e;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/probe_scan_display_seg7_hex_decode.sv
// seg7_hex_decode: 4-bit nibble to active-low gfedcba segment pattern
module seg7_hex_decode
    import probe_scan_display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = HEX_SEG[nib_i];
endmodule

// File: rtl/probe_scan_display.sv
// probe_scan_display: channel select with hold/strobe snapshot bank driving a scanned 7-segment display
module probe_scan_display
    import probe_scan_display_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int DATA_W   = 32,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int SEL_W    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic [1:0]               mode,
    input  logic                     cap_stb,
    input  logic                     blank_lz,
    output logic [DIGITS-1:0]        AN,
    output logic [7:0]               Seg,
    output logic [DATA_W-1:0]        shown
);
    localparam int IDX_W = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    logic [DATA_W-1:0] snap_q [NUM_CH];
    logic [1:0]        prev_mode_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shown_d, live_w, snap_w, nib_src;
    logic [DIGITS-1:0] an_d;
    logic [7:0]        seg_d;
    logic [6:0]        hex;
    logic              frozen, snap_we, blank;
    always_comb begin
        live_w = '0;
        snap_w = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(sel) == k) begin
                live_w = ch_data[k*DATA_W +: DATA_W];
                snap_w = snap_q[k];
            end
        end
        frozen  = mode == MODE_HOLD || mode == MODE_STROBE;
        snap_we = (mode == MODE_HOLD && prev_mode_q != MODE_HOLD) || (mode == MODE_STROBE && cap_stb);
        shown_d = frozen && !snap_we ? snap_w : live_w;
        div_d   = div_q == DIV_W'(SCAN_DIV - 1) ? '0 : div_q + DIV_W'(1);
        idx_d   = div_q != DIV_W'(SCAN_DIV - 1) ? idx_q : idx_q == IDX_W'(DIGITS - 1) ? '0 : idx_q + IDX_W'(1);
        nib_src = shown >> {idx_q, 2'b00};
        blank   = blank_lz && idx_q != '0 && nib_src == '0;
        an_d    = ~(DIGITS'(1) << idx_q);
        seg_d   = {!(idx_q == '0 && frozen), blank ? SEG_BLANK : hex};
    end
    seg7_hex_decode u_dec (
        .nib_i (nib_src[3:0]),
        .seg_o (hex)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            idx_q       <= '0;
            prev_mode_q <= MODE_LIVE;
            shown       <= '0;
            AN          <= '1;
            Seg         <= '1;
            for (int k = 0; k < NUM_CH; k++) snap_q[k] <= '0;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            prev_mode_q <= mode;
            shown       <= shown_d;
            AN          <= an_d;
            Seg         <= seg_d;
            if (snap_we) for (int k = 0; k < NUM_CH; k++) snap_q[k] <= ch_data[k*DATA_W +: DATA_W];
        end
    end
endmodule

// File: tb/tb_probe_scan_display.sv
// tb_probe_scan_display: scoreboard bench with a cycle-level reference model, 8- and 6-channel instances
module tb_probe_scan_display;
    localparam int NCH = 8, W = 32, DG = 8, SD = 4;
    logic           clk = 0, reset = 1, cap_stb = 0, blank_lz = 0;
    logic [NCH*W-1:0] ch_data = '0;
    logic [2:0]     sel = '0;
    logic [1:0]     mode = '0;
    logic [DG-1:0]  AN, AN6;
    logic [7:0]     Seg, Seg6;
    logic [W-1:0]   shown, shown6;
    always #5 clk = ~clk;
    probe_scan_display #(.NUM_CH(NCH), .DATA_W(W), .DIGITS(DG), .SCAN_DIV(SD), .SEL_W(3)) dut (
        .clk(clk), .reset(reset), .ch_data(ch_data), .sel(sel), .mode(mode), .cap_stb(cap_stb),
        .blank_lz(blank_lz), .AN(AN), .Seg(Seg), .shown(shown)
    );
    probe_scan_display #(.NUM_CH(6), .DATA_W(W), .DIGITS(DG), .SCAN_DIV(SD), .SEL_W(3)) dut6 (
        .clk(clk), .reset(reset), .ch_data(ch_data[6*W-1:0]), .sel(sel), .mode(mode), .cap_stb(cap_stb),
        .blank_lz(blank_lz), .AN(AN6), .Seg(Seg6), .shown(shown6)
    );
    typedef struct packed {
        logic [31:0] sh;
        logic [31:0] sh6;
        logic [7:0]  an;
        logic [7:0]  seg;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;
    logic [6:0] hex_tb [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [31:0] m_snap [NCH];
    logic [31:0] m_shown;
    logic [1:0]  m_prev;
    int          m_t;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: digit position follows from edges since reset; snapshot is the bank after this edge.
    task automatic step();
        exp_t        e;
        int          idx;
        logic [31:0] rest;
        logic        frz;
        if (reset) begin
            m_t = 0;
            m_prev = 0;
            m_shown = 0;
            foreach (m_snap[k]) m_snap[k] = 0;
            e = '{32'h0, 32'h0, 8'hFF, 8'hFF};
        end else begin
            frz   = mode == 2'd1 || mode == 2'd2;
            idx   = (m_t / SD) % DG;
            rest  = m_shown >> (4 * idx);
            e.an  = ~(8'd1 << idx);
            e.seg = {!(idx == 0 && frz), (blank_lz && idx != 0 && rest == 0) ? 7'h7F : hex_tb[rest[3:0]]};
            if ((mode == 2'd1 && m_prev != 2'd1) || (mode == 2'd2 && cap_stb))
                for (int k = 0; k < NCH; k++) m_snap[k] = ch_data[k*W +: W];
            m_shown = frz ? m_snap[sel] : ch_data[sel*W +: W];
            e.sh  = m_shown;
            e.sh6 = sel >= 3'd6 ? 32'h0 : m_shown;
            m_prev = mode;
            m_t++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask
    task automatic run(int n);
        repeat (n) step();
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("shown", shown, e.sh);
            chk("shown6", shown6, e.sh6);
            chk("AN", {24'h0, AN}, {24'h0, e.an});
            chk("Seg", {24'h0, Seg}, {24'h0, e.seg});
        end
    end
    initial begin
        run(3);
        reset = 0;
        ch_data[2*W +: W] = 32'h1234_ABCD;
        sel = 3'd2;
        run(40);
        ch_data[0*W +: W] = 32'hAAAA_0000;
        ch_data[5*W +: W] = 32'h0000_0055;
        sel = 3'd0;
        mode = 2'd1;
        step();
        ch_data[0*W +: W] = 32'h1111_1111;
        ch_data[5*W +: W] = 32'h2222_2222;
        sel = 3'd5;
        run(40);
        mode = 2'd0;
        step();
        ch_data[4*W +: W] = 32'h4444_0044;
        mode = 2'd1;
        sel = 3'd4;
        run(5);
        mode = 2'd2;
        sel = 3'd1;
        ch_data[1*W +: W] = 32'hDEAD_BEEF;
        cap_stb = 1;
        step();
        cap_stb = 0;
        ch_data[1*W +: W] = 32'h0000_0001;
        run(10);
        ch_data[1*W +: W] = 32'hCAFE_F00D;
        cap_stb = 1;
        step();
        cap_stb = 0;
        run(10);
        mode = 2'd3;
        blank_lz = 1;
        sel = 3'd3;
        ch_data[3*W +: W] = 32'h0000_00F0;
        run(40);
        ch_data[3*W +: W] = 32'h0;
        run(40);
        blank_lz = 0;
        ch_data[7*W +: W] = 32'h7777_7777;
        ch_data[6*W +: W] = 32'h6666_6666;
        sel = 3'd7;
        run(5);
        sel = 3'd6;
        run(18);
        reset = 1;
        step();
        reset = 0;
        run(10);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) reset = 1;
            else reset = 0;
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
            cap_stb = $urandom_range(0, 5) == 0;
            for (int k = 0; k < NCH; k++)
                if ($urandom_range(0, 3) == 0) ch_data[k*W +: W] = $urandom >> $urandom_range(0, 32);
            step();
        end
        reset = 0;
        cap_stb = 0;
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
